// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package seq_magnitude_comparator_pkg;

  // Controller states: waiting for a request, or walking the operand slices.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CMP  = 1'b1
  } state_t;

  // Result flags packed as {albo, aebo, agbo}; exactly one bit is set after a compare.
  typedef logic [2:0] res_t;

  localparam res_t RES_NONE = 3'b000;
  localparam res_t RES_LT   = 3'b100;
  localparam res_t RES_EQ   = 3'b010;
  localparam res_t RES_GT   = 3'b001;

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Request/result bundle for the sequential magnitude comparator.
//
// Handshake: the requester raises start together with a, b and signed_mode;
// the comparator accepts it on a rising edge only while busy=0. From that
// edge busy stays high until the result edge, after which done is high for
// exactly one cycle and albo/aebo/agbo/slices_used hold the new result until
// the next done. start raised while busy=1 is dropped, and start raised in
// the done cycle is accepted because the comparator is already idle.
interface seq_magnitude_comparator_if
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) ();

  localparam int SW = $clog2(WIDTH / DIGIT) + 1;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             albo;
  logic             aebo;
  logic             agbo;
  logic [SW-1:0]    slices_used;
  state_t           dbg_state;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, albo, aebo, agbo, slices_used, dbg_state
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, albo, aebo, agbo, slices_used, dbg_state
  );

endinterface

// File: rtl/seq_magnitude_comparator_cmp_slice.sv
// Unsigned compare of one DIGIT-wide slice of each operand.
module seq_magnitude_comparator_cmp_slice #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_s,
  input  logic [DIGIT-1:0] b_s,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = (a_s <  b_s);
  assign eq = (a_s == b_s);
  assign gt = (a_s >  b_s);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands MSB-first, DIGIT bits
// per cycle, and stops at the first differing slice.
module seq_magnitude_comparator
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIGIT     = 2,
  parameter bit SIGNED_EN = 1'b1
) (
  input logic                         clk,
  input logic                         rst_n,
  seq_magnitude_comparator_if.slave   bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(N) + 1;

  localparam logic [KW-1:0]    K_LAST   = KW'(N - 1);
  localparam logic [SW-1:0]    SLICES_N = SW'(N);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("seq_magnitude_comparator: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  res_t             res_q, res_d;
  logic [SW-1:0]    slices_q, slices_d;
  logic [WIDTH-1:0] flip;

  logic s_lt, s_eq, s_gt;

  // The operand registers shift left, so the slice under test is always the top DIGIT bits.
  seq_magnitude_comparator_cmp_slice #(.DIGIT(DIGIT)) u_slice (
    .a_s (a_q[WIDTH-1 -: DIGIT]),
    .b_s (b_q[WIDTH-1 -: DIGIT]),
    .lt  (s_lt),
    .eq  (s_eq),
    .gt  (s_gt)
  );

  // Next-state and next-output logic for the compare controller.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    res_d    = res_q;
    slices_d = slices_q;
    flip     = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // Flipping both sign bits maps two's complement onto offset binary,
          // so the slice logic only ever needs an unsigned compare.
          if (SIGNED_EN && bus.signed_mode) flip = MSB_MASK;
          a_d     = bus.a ^ flip;
          b_d     = bus.b ^ flip;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        if (s_lt || s_gt) begin
          res_d    = s_lt ? RES_LT : RES_GT;
          slices_d = SW'(k_q) + SW'(1);
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else if (k_q == K_LAST) begin
          res_d    = RES_EQ;
          slices_d = SLICES_N;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          k_d = k_q + KW'(1);
          a_d = a_q << DIGIT;
          b_d = b_q << DIGIT;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any compare in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= RES_NONE;
      slices_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_q    <= res_d;
      slices_q <= slices_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.albo        = res_q[2];
  assign bus.aebo        = res_q[1];
  assign bus.agbo        = res_q[0];
  assign bus.slices_used = slices_q;
  assign bus.dbg_state   = state_q;

endmodule
